hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the in-order MIPS pipeline. It keeps its own registered record of every in-flight writer between E and W, and from those records computes the decode stall and per-stage forwarding selects. It also runs an internal multi-cycle multiply/divide busy counter, an EPC-write interlock for `eret`, and a saturating stall-cycle counter. It sits beside the datapath and replaces the purely combinational stall/forward logic; the datapath muxes forwarded values using its select outputs.

---
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight writer records driving decode stall, forwarding selects, md interlock and stall count
module hazard_scoreboard #(
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int DEPTH   = 3,
    parameter int SW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                d_valid,
    input  logic [AW-1:0]       d_rs,
    input  logic [AW-1:0]       d_rt,
    input  logic [TW-1:0]       d_rs_use,
    input  logic [TW-1:0]       d_rt_use,
    input  logic [AW-1:0]       d_dst,
    input  logic [TW-1:0]       d_tnew,
    input  logic                d_md,
    input  logic                d_md_start,
    input  logic                d_md_div,
    input  logic                d_mtc0_epc,
    input  logic                d_eret,
    input  logic                flush,
    output logic                stall,
    output logic [DEPTH*SW-1:0] fwd_rs_sel,
    output logic [DEPTH*SW-1:0] fwd_rt_sel,
    output logic                md_busy,
    output logic [31:0]         stall_cnt
);
    localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
    localparam int CW = $clog2(MAX_LAT + 1);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] dst;
        logic [TW-1:0] tnew;
        logic          md_start;
        logic          mtc0_epc;
    } rec_t;

    rec_t          rec [1:DEPTH];
    rec_t          d_ent;
    logic [CW-1:0] md_cnt;
    logic [AW-1:0] c_rs [DEPTH];
    logic [AW-1:0] c_rt [DEPTH];
    logic [TW-1:0] rs_tnew, rt_tnew;
    logic          epc_pend, issue, unused_bits;

    function automatic rec_t age(input rec_t r);
        rec_t a;
        a = r;
        a.tnew = r.tnew - TW'(r.tnew != '0);
        return a;
    endfunction

    assign d_ent = '{1'b1, d_rs, d_rt, d_dst, d_tnew, d_md_start, d_mtc0_epc};
    assign md_busy = md_cnt != '0;
    assign issue = d_valid && !stall && !flush;

    // scanning oldest to youngest lets the youngest match overwrite older ones;
    // no match leaves tnew at 0, which can never exceed a Tuse
    always_comb begin
        rs_tnew = '0;
        rt_tnew = '0;
        epc_pend = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (rec[k].valid && d_rs != '0 && rec[k].dst == d_rs)
                rs_tnew = rec[k].tnew;
            if (rec[k].valid && d_rt != '0 && rec[k].dst == d_rt)
                rt_tnew = rec[k].tnew;
        end
        for (int k = 1; k < DEPTH; k++)
            epc_pend = epc_pend | (rec[k].valid & rec[k].mtc0_epc);
        stall = d_valid && ((d_rs_use != '1 && d_rs_use < rs_tnew) ||
                            (d_rt_use != '1 && d_rt_use < rt_tnew) ||
                            (d_md && md_busy) || (d_eret && epc_pend));
    end

    always_comb begin
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        c_rs[0] = d_rs;
        c_rt[0] = d_rt;
        for (int j = 1; j < DEPTH; j++) begin
            c_rs[j] = rec[j].rs;
            c_rt[j] = rec[j].rt;
        end
        for (int j = 0; j < DEPTH; j++)
            for (int k = DEPTH; k > j; k--) begin
                if (rec[k].valid && c_rs[j] != '0 && rec[k].dst == c_rs[j])
                    fwd_rs_sel[j*SW +: SW] = rec[k].tnew == '0 ? SW'(k) : '0;
                if (rec[k].valid && c_rt[j] != '0 && rec[k].dst == c_rt[j])
                    fwd_rt_sel[j*SW +: SW] = rec[k].tnew == '0 ? SW'(k) : '0;
            end
    end

    always_comb begin
        unused_bits = ^{rec[DEPTH].rs, rec[DEPTH].rt, rec[DEPTH].mtc0_epc};
        for (int k = 1; k <= DEPTH; k++)
            unused_bits = unused_bits ^ rec[k].md_start;
    end

    // flush clears E..DEPTH-1 but the record leaving DEPTH-1 still retires into DEPTH
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 1; k <= DEPTH; k++)
                rec[k] <= '0;
            md_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            rec[1] <= issue ? d_ent : '0;
            for (int k = 2; k <= DEPTH; k++)
                rec[k] <= (flush && k < DEPTH) ? '0 : age(rec[k-1]);
            md_cnt <= (issue && d_md_start) ? CW'(d_md_div ? DIV_LAT : MUL_LAT) : md_cnt - CW'(md_busy);
            stall_cnt <= stall_cnt + 32'(stall && stall_cnt != '1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table, multi-cycle sequences and a queue-based random reference model
module tb_hazard_scoreboard;
    localparam int AW = 5, TW = 2, DEPTH = 3, SW = 2, MUL_LAT = 5, DIV_LAT = 10;

    logic clk = 1'b0;
    logic reset_n, d_valid, d_md, d_md_start, d_md_div, d_mtc0_epc, d_eret, flush;
    logic [AW-1:0] d_rs, d_rt, d_dst;
    logic [TW-1:0] d_rs_use, d_rt_use, d_tnew;
    logic stall, md_busy;
    logic [DEPTH*SW-1:0] fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cnt;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.AW(AW), .TW(TW), .DEPTH(DEPTH), .SW(SW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_use(d_rs_use), .d_rt_use(d_rt_use), .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md(d_md), .d_md_start(d_md_start), .d_md_div(d_md_div), .d_mtc0_epc(d_mtc0_epc),
        .d_eret(d_eret), .flush(flush), .stall(stall), .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic v;
        logic [4:0] rs, rt, dst;
        logic [1:0] rsu, rtu, tn;
        logic md, ms, div, epc, eret, fl;
    } in_t;

    typedef struct {
        in_t i;
        logic st;
        logic [5:0] rsel, rtsel;
        logic busy;
        logic [31:0] cnt;
    } vec_t;

    function automatic in_t op(logic v, int rs, int rsu, int rt, int rtu, int dst, int tn);
        in_t x;
        x.v = v; x.rs = 5'(rs); x.rsu = 2'(rsu); x.rt = 5'(rt); x.rtu = 2'(rtu);
        x.dst = 5'(dst); x.tn = 2'(tn);
        x.md = 0; x.ms = 0; x.div = 0; x.epc = 0; x.eret = 0; x.fl = 0;
        return x;
    endfunction

    task automatic apply(input in_t x);
        d_valid = x.v; d_rs = x.rs; d_rt = x.rt; d_rs_use = x.rsu; d_rt_use = x.rtu;
        d_dst = x.dst; d_tnew = x.tn; d_md = x.md; d_md_start = x.ms; d_md_div = x.div;
        d_mtc0_epc = x.epc; d_eret = x.eret; flush = x.fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string nm, input logic st, input logic [5:0] rs, input logic [5:0] rt,
                             input logic busy, input logic [31:0] cnt);
        check({nm, ".stall"}, 32'(stall), 32'(st));
        check({nm, ".rs_sel"}, 32'(fwd_rs_sel), 32'(rs));
        check({nm, ".rt_sel"}, 32'(fwd_rt_sel), 32'(rt));
        check({nm, ".md_busy"}, 32'(md_busy), 32'(busy));
        check({nm, ".stall_cnt"}, stall_cnt, cnt);
    endtask

    // reference model: each in-flight instruction remembers the cycle it entered E
    typedef struct { int enter; int rs, rt, dst, tnew; bit epc; } inst_t;
    inst_t pipe[$];
    int cyc = 0, md_end = 0;
    longint m_cnt = 0;

    function automatic int stg(int i);
        return cyc - pipe[i].enter + 1;
    endfunction

    function automatic int left(int i);
        int t;
        t = pipe[i].tnew - (stg(i) - 1);
        return t < 0 ? 0 : t;
    endfunction

    function automatic int prod(int r, int j);
        int b;
        b = -1;
        if (r == 0) return -1;
        foreach (pipe[i])
            if (stg(i) > j && pipe[i].dst == r && (b < 0 || stg(i) < stg(b))) b = i;
        return b;
    endfunction

    function automatic int src(int j, bit is_rt, in_t x);
        if (j == 0) return is_rt ? int'(x.rt) : int'(x.rs);
        foreach (pipe[i])
            if (stg(i) == j) return is_rt ? pipe[i].rt : pipe[i].rs;
        return 0;
    endfunction

    function automatic logic [5:0] sel_exp(bit is_rt, in_t x);
        logic [5:0] s;
        int p;
        s = '0;
        for (int j = 0; j < DEPTH; j++) begin
            p = prod(src(j, is_rt, x), j);
            if (p >= 0 && left(p) == 0) s[j*SW +: SW] = SW'(stg(p));
        end
        return s;
    endfunction

    function automatic bit stall_exp(in_t x);
        int p;
        bit s;
        s = 0;
        p = prod(int'(x.rs), 0);
        if (p >= 0 && x.rsu != 3 && int'(x.rsu) < left(p)) s = 1;
        p = prod(int'(x.rt), 0);
        if (p >= 0 && x.rtu != 3 && int'(x.rtu) < left(p)) s = 1;
        if (x.md && cyc < md_end) s = 1;
        if (x.eret) foreach (pipe[i]) if (pipe[i].epc && stg(i) < DEPTH) s = 1;
        return x.v && s;
    endfunction

    task automatic model_edge(input in_t x, input logic rn, input bit st);
        inst_t n;
        if (!rn) begin
            pipe.delete();
            md_end = 0;
            m_cnt = 0;
            cyc++;
            return;
        end
        if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (x.fl)
            for (int i = pipe.size() - 1; i >= 0; i--)
                if (stg(i) < DEPTH - 1) pipe.delete(i);
        if (x.v && !st && !x.fl) begin
            n.enter = cyc + 1; n.rs = int'(x.rs); n.rt = int'(x.rt); n.dst = int'(x.dst);
            n.tnew = int'(x.tn); n.epc = x.epc;
            pipe.push_back(n);
            if (x.ms) md_end = cyc + 1 + (x.div ? DIV_LAT : MUL_LAT);
        end
        cyc++;
        while (pipe.size() > 0 && stg(0) > DEPTH) void'(pipe.pop_front());
    endtask

    initial begin
        vec_t vecs[12];
        in_t nop, x, y;
        nop = op(0, 0, 3, 0, 3, 0, 0);
        // load-use, ALU chain, $0 destination, youngest-wins
        vecs[0]  = '{op(1, 1, 1, 0, 3, 5, 2), 1'b0, 6'd0,  6'd0,  1'b0, 32'd0};
        vecs[1]  = '{op(1, 5, 1, 0, 3, 6, 1), 1'b1, 6'd0,  6'd0,  1'b0, 32'd0};
        vecs[2]  = '{op(1, 5, 1, 0, 3, 6, 1), 1'b0, 6'd0,  6'd0,  1'b0, 32'd1};
        vecs[3]  = '{nop,                     1'b0, 6'd12, 6'd0,  1'b0, 32'd1};
        vecs[4]  = '{op(1, 0, 3, 0, 3, 3, 1), 1'b0, 6'd0,  6'd0,  1'b0, 32'd1};
        vecs[5]  = '{op(1, 3, 1, 3, 1, 4, 1), 1'b0, 6'd0,  6'd0,  1'b0, 32'd1};
        vecs[6]  = '{nop,                     1'b0, 6'd8,  6'd8,  1'b0, 32'd1};
        vecs[7]  = '{op(1, 0, 3, 0, 3, 0, 1), 1'b0, 6'd48, 6'd48, 1'b0, 32'd1};
        vecs[8]  = '{op(1, 0, 1, 0, 1, 0, 1), 1'b0, 6'd0,  6'd0,  1'b0, 32'd1};
        vecs[9]  = '{op(1, 0, 3, 0, 3, 8, 0), 1'b0, 6'd0,  6'd0,  1'b0, 32'd1};
        vecs[10] = '{op(1, 0, 3, 0, 3, 8, 0), 1'b0, 6'd0,  6'd0,  1'b0, 32'd1};
        vecs[11] = '{op(1, 8, 0, 8, 0, 0, 0), 1'b0, 6'd1,  6'd1,  1'b0, 32'd1};

        apply(nop);
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        #1;
        check_all("reset", 1'b0, 6'd0, 6'd0, 1'b0, 32'd0);

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].i);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].rsel, vecs[i].rtsel, vecs[i].busy, vecs[i].cnt);
            step();
        end

        apply(nop);
        repeat (3) step();
        // div then mult, each followed by an md consumer held in D
        for (int m = 0; m < 2; m++) begin
            x = op(1, 0, 3, 0, 3, 0, 0);
            x.md = 1; x.ms = 1; x.div = (m == 0);
            apply(x);
            #1;
            check("md_issue", 32'(stall), 32'd0);
            step();
            y = op(1, 0, 3, 0, 3, 2, 0);
            y.md = 1;
            apply(y);
            for (int c = 0; c < (m == 0 ? DIV_LAT : MUL_LAT); c++) begin
                #1;
                check("md_stall", 32'(stall), 32'd1);
                check("md_busy", 32'(md_busy), 32'd1);
                step();
            end
            #1;
            check("md_release", 32'(stall), 32'd0);
            check("md_idle", 32'(md_busy), 32'd0);
            check("md_cnt", stall_cnt, m == 0 ? 32'd11 : 32'd16);
            step();
        end

        x = op(1, 0, 3, 0, 3, 0, 0);
        x.epc = 1;
        apply(x);
        #1;
        check("epc_issue", 32'(stall), 32'd0);
        step();
        x = op(1, 0, 3, 0, 3, 0, 0);
        x.eret = 1;
        apply(x);
        for (int c = 0; c < DEPTH - 1; c++) begin
            #1;
            check("eret_stall", 32'(stall), 32'd1);
            step();
        end
        #1;
        check("eret_release", 32'(stall), 32'd0);
        check("eret_cnt", stall_cnt, 32'd18);
        step();

        apply(nop);
        repeat (3) step();
        apply(op(1, 1, 1, 0, 3, 5, 2));
        #1;
        step();
        x = op(1, 5, 1, 0, 3, 6, 1);
        x.fl = 1;
        apply(x);
        #1;
        check("flush_cycle_stall", 32'(stall), 32'd1);
        step();
        x.fl = 0;
        apply(x);
        #1;
        check("flush_no_stall", 32'(stall), 32'd0);
        check("flush_sel", 32'(fwd_rs_sel), 32'd0);
        check("flush_cnt", stall_cnt, 32'd19);
        step();

        apply(nop);
        repeat (3) step();
        x = op(1, 0, 3, 0, 3, 0, 0);
        x.md = 1; x.ms = 1; x.div = 1;
        apply(x);
        #1;
        step();
        y = op(1, 0, 3, 0, 3, 2, 0);
        y.md = 1;
        apply(y);
        #1;
        check("rst_pre_stall", 32'(stall), 32'd1);
        reset_n = 1'b0;
        step();
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset_n = 1'b1;

        for (int n = 0; n < 4000; n++) begin
            logic rn;
            bit es;
            x = op($urandom % 8 != 0, $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4,
                   $urandom % 4, $urandom % 4);
            x.md = $urandom % 6 == 0;
            x.ms = $urandom % 16 == 0;
            x.div = $urandom % 2 == 0;
            x.epc = $urandom % 10 == 0;
            x.eret = $urandom % 8 == 0;
            x.fl = $urandom % 20 == 0;
            rn = n == 0 ? 1'b0 : ($urandom % 300 != 0);
            apply(x);
            reset_n = rn;
            #1;
            if (n > 0) begin
                es = stall_exp(x);
                check("rnd.stall", 32'(stall), 32'(es));
                check("rnd.rs_sel", 32'(fwd_rs_sel), 32'(sel_exp(0, x)));
                check("rnd.rt_sel", 32'(fwd_rt_sel), 32'(sel_exp(1, x)));
                check("rnd.md_busy", 32'(md_busy), 32'(cyc < md_end));
                check("rnd.stall_cnt", stall_cnt, 32'(m_cnt));
            end else
                es = 0;
            @(posedge clk);
            model_edge(x, rn, es);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
